// File: rtl/task_sched_if.sv
// -----------------------------------------------------------------------------
// task_sched_if
//   Bundles every non-clock signal of the task scheduler: per-tree request
//   lanes, the task FIFO write/read sides, the PIFO core task output and a
//   debug view of the read FSM state.
//
//   Modports:
//     slave  - the scheduler itself (task_sched)
//     master - the surrounding logic (request lanes, FIFO, PIFO core)
//
//   Signals:
//     req_valid/req_push/req_data  per-tree request, op (1=push) and payload
//     req_grant                    one-hot accept, same cycle as req_valid
//     fifo_wr_en/fifo_buf_in       FIFO write strobe and task word
//     fifo_full/fifo_empty         FIFO status
//     fifo_rd_en/fifo_buf_out      FIFO read strobe and read data (next cycle)
//     pifo_ready                   PIFO core can accept a task
//     task_valid/push/tree/data    decoded task to the PIFO core
//     dbg_state                    read FSM state (0 IDLE, 1 ISSUE, 2 GAP)
// -----------------------------------------------------------------------------
interface task_sched_if #(
   parameter int PTW           = 16,
   parameter int TREE_NUM      = 4,
   parameter int TREE_NUM_BITS = $clog2(TREE_NUM)
);
   localparam int TW = PTW + TREE_NUM_BITS + 1;

   logic [TREE_NUM-1:0]     req_valid;
   logic [TREE_NUM-1:0]     req_push;
   logic [TREE_NUM*PTW-1:0] req_data;
   logic [TREE_NUM-1:0]     req_grant;
   logic                    fifo_wr_en;
   logic [TW-1:0]           fifo_buf_in;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_rd_en;
   logic [TW-1:0]           fifo_buf_out;
   logic                    pifo_ready;
   logic                    task_valid;
   logic                    task_push;
   logic [TREE_NUM_BITS-1:0] task_tree;
   logic [PTW-1:0]          task_data;
   logic [1:0]              dbg_state;

   modport slave (
      input  req_valid, req_push, req_data, fifo_full, fifo_empty,
             fifo_buf_out, pifo_ready,
      output req_grant, fifo_wr_en, fifo_buf_in, fifo_rd_en,
             task_valid, task_push, task_tree, task_data, dbg_state
   );

   modport master (
      output req_valid, req_push, req_data, fifo_full, fifo_empty,
             fifo_buf_out, pifo_ready,
      input  req_grant, fifo_wr_en, fifo_buf_in, fifo_rd_en,
             task_valid, task_push, task_tree, task_data, dbg_state
   );
endinterface

// File: rtl/task_sched.sv
// -----------------------------------------------------------------------------
// task_sched
//   Front-end scheduler for the shared vPIFO task FIFO. Arbitrates one request
//   per cycle from TREE_NUM trees, encodes the winner as {op, tree_id, data}
//   into the FIFO, and paces FIFO reads so the PIFO core sees at most one task
//   every OP_GAP+2 cycles, only while pifo_ready is high.
//
//   Ports:
//     clk  - system clock
//     rst  - asynchronous reset, active-low
//     bus  - task_sched_if.slave (requests, FIFO sides, task output, dbg_state)
//
//   Configuration macro:
//     TASK_SCHED_STRICT_PRIO_EN - when defined, lowest tree index always wins
//                                 and the round-robin pointer is removed.
//
//   Handshake semantics: a request on tree i is accepted in exactly the cycle
//   where req_valid[i] and req_grant[i] are both high; the grant is
//   combinational and also raises fifo_wr_en that cycle. No grant is issued
//   while fifo_full is high. A FIFO read is requested by a single-cycle
//   fifo_rd_en; fifo_buf_out is expected to hold the entry the cycle after,
//   when task_valid is high. The PIFO core has no back-pressure on a task
//   already issued: pifo_ready only gates the start of a new read.
// -----------------------------------------------------------------------------
module task_sched #(
   parameter int PTW           = 16,
   parameter int TREE_NUM      = 4,
   parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
   parameter int OP_GAP        = 2
) (
   input  logic          clk,
   input  logic          rst,
   task_sched_if.slave   bus
);
   localparam int TW = PTW + TREE_NUM_BITS + 1;
   localparam logic [3:0] GAP_LOAD = (OP_GAP == 0) ? 4'd0 : 4'(OP_GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [3:0]               gap_cnt_q, gap_cnt_d;
   logic                     task_valid_q, task_valid_d;
   logic                     rd_en;

   logic                     found;
   logic                     grant_en;
   logic [TREE_NUM_BITS-1:0] win;
   logic [TREE_NUM_BITS-1:0] cand;
   logic [TREE_NUM-1:0]      grant_vec;
   logic                     push_w;
   logic [PTW-1:0]           data_w;

`ifndef TASK_SCHED_STRICT_PRIO_EN
   logic [TREE_NUM_BITS-1:0] rr_ptr_q, rr_ptr_d;
`endif

   // Winner search: first requesting tree scanning upward from the start
   // point, wrapping. Strict mode always starts at tree 0.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < TREE_NUM; k++) begin
`ifdef TASK_SCHED_STRICT_PRIO_EN
         cand = TREE_NUM_BITS'(k);
`else
         cand = TREE_NUM_BITS'((int'(rr_ptr_q) + k) % TREE_NUM);
`endif
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Grant is also held off during reset so nothing is written into the FIFO
   // before the scheduler state is valid.
   always_comb begin
      grant_en       = found && !bus.fifo_full && rst;
      grant_vec      = '0;
      grant_vec[win] = 1'b1;
      push_w         = bus.req_push[win];
      data_w         = bus.req_data[int'(win)*PTW +: PTW];
      bus.req_grant  = grant_en ? grant_vec : '0;
      bus.fifo_wr_en = grant_en;
      bus.fifo_buf_in = grant_en ? {push_w, win, (push_w ? data_w : {PTW{1'b0}})}
                                 : {TW{1'b0}};
   end

`ifndef TASK_SCHED_STRICT_PRIO_EN
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_en) begin
         rr_ptr_d = (win == TREE_NUM_BITS'(TREE_NUM - 1)) ? '0
                                                          : win + TREE_NUM_BITS'(1);
      end
   end
`endif

   // Read pacing FSM: one ISSUE cycle, then OP_GAP cycles of GAP, then at
   // least one IDLE cycle, giving OP_GAP+2 cycles between reads.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      rd_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.pifo_ready && !bus.fifo_empty) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            rd_en = 1'b1;
            if (OP_GAP == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_GAP;
               gap_cnt_d = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 4'd0) state_d = ST_IDLE;
            else                   gap_cnt_d = gap_cnt_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      task_valid_d = rd_en;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         gap_cnt_q    <= 4'd0;
         task_valid_q <= 1'b0;
`ifndef TASK_SCHED_STRICT_PRIO_EN
         rr_ptr_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         gap_cnt_q    <= gap_cnt_d;
         task_valid_q <= task_valid_d;
`ifndef TASK_SCHED_STRICT_PRIO_EN
         rr_ptr_q     <= rr_ptr_d;
`endif
      end
   end

   // Task fields are only driven while the FIFO read data is the task.
   always_comb begin
      bus.fifo_rd_en = rd_en;
      bus.task_valid = task_valid_q;
      bus.task_push  = task_valid_q & bus.fifo_buf_out[TW-1];
      bus.task_tree  = task_valid_q ? bus.fifo_buf_out[PTW +: TREE_NUM_BITS]
                                    : '0;
      bus.task_data  = (task_valid_q && bus.fifo_buf_out[TW-1])
                       ? bus.fifo_buf_out[PTW-1:0] : '0;
      bus.dbg_state  = state_q;
   end
endmodule

// File: tb/tb_task_sched.sv
module tb_task_sched;
   localparam int PTW = 16;
   localparam int TN  = 4;
   localparam int TW  = 19;
`ifdef TASK_SCHED_STRICT_PRIO_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task_sched_if #(.PTW(PTW), .TREE_NUM(TN)) bus ();

   task_sched #(.PTW(PTW), .TREE_NUM(TN), .OP_GAP(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- FIFO model ----------------
   logic [TW-1:0] mem_q[$];
   int            fifo_cnt = 0;
   logic          force_full;
   assign bus.fifo_empty = (fifo_cnt == 0);
   assign bus.fifo_full  = force_full || (fifo_cnt >= 16);
   always @(posedge clk) begin
      if (bus.fifo_rd_en && mem_q.size() > 0) bus.fifo_buf_out <= mem_q.pop_front();
      if (bus.fifo_wr_en) mem_q.push_back(bus.fifo_buf_in);
      fifo_cnt <= mem_q.size();
   end

   // ---------------- scoreboard ----------------
   logic [63:0] wr_exp_q[$];
   logic [63:0] rd_exp_q[$];
   logic [63:0] task_exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
   endtask

   function automatic logic [TW-1:0] word(input logic p, input logic [1:0] t,
                                          input logic [15:0] d);
      return {p, t, (p ? d : 16'h0000)};
   endfunction

   function automatic logic [63:0] wr_e(input int c, input logic [3:0] g,
                                        input logic [TW-1:0] w);
      return {8'h00, c, 1'b1, g, w};
   endfunction

   function automatic logic [63:0] tk_e(input int c, input logic [TW-1:0] w);
      return {13'h0, c, w};
   endfunction

   // Monitor: sampled in the low phase, well away from the rising edge.
   always @(negedge clk) begin
      #2;
      if (bus.fifo_wr_en || bus.req_grant != '0) begin
         if (wr_exp_q.size() == 0)
            unexpected("write", {bus.fifo_wr_en, bus.req_grant, bus.fifo_buf_in});
         else
            chk("write", {8'h00, cyc, bus.fifo_wr_en, bus.req_grant, bus.fifo_buf_in},
                wr_exp_q.pop_front());
      end
      if (bus.fifo_rd_en) begin
         if (rd_exp_q.size() == 0) unexpected("fifo_rd_en", 64'(cyc));
         else                      chk("fifo_rd_en_cycle", 64'(cyc), rd_exp_q.pop_front());
      end
      if (bus.task_valid) begin
         if (task_exp_q.size() == 0)
            unexpected("task", {bus.task_push, bus.task_tree, bus.task_data});
         else
            chk("task", {13'h0, cyc, bus.task_push, bus.task_tree, bus.task_data},
                task_exp_q.pop_front());
      end else begin
         chk("task_idle_zero", {bus.task_push, bus.task_tree, bus.task_data}, 64'h0);
      end
   end

   // ---------------- driver helpers ----------------
   task automatic set_req(input logic [3:0] v, input logic [3:0] p,
                          input logic [63:0] d);
      bus.req_valid = v;
      bus.req_push  = p;
      bus.req_data  = d;
   endtask

   // ---------------- stimulus ----------------
   logic [15:0]   rr_d [4];
   logic [TW-1:0] pend_q[$];
   int            c;
   int            w;

   initial begin
      rr_d[0] = 16'hA000; rr_d[1] = 16'hB111; rr_d[2] = 16'hC222; rr_d[3] = 16'hD333;
      rst = 1'b0;
      force_full = 1'b0;
      bus.pifo_ready = 1'b1;
      set_req(4'b1111, 4'b1111, 64'h0);

      // Reset: grants held off even with all trees requesting.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_grant",      64'(bus.req_grant),  64'h0);
      chk("rst_wr_en",      64'(bus.fifo_wr_en), 64'h0);
      chk("rst_rd_en",      64'(bus.fifo_rd_en), 64'h0);
      chk("rst_task_valid", 64'(bus.task_valid), 64'h0);
      chk("rst_state",      64'(bus.dbg_state),  64'h0);
      @(negedge clk);
      rst = 1'b1;
      set_req(4'b0000, 4'b0000, 64'h0);

      // Idle with empty FIFO and pifo_ready high: no read.
      repeat (6) @(negedge clk);
      #1;
      chk("idle_state", 64'(bus.dbg_state),  64'h0);
      chk("idle_rd_en", 64'(bus.fifo_rd_en), 64'h0);

      // All four trees pushing continuously, PIFO not ready: no reads.
      bus.pifo_ready = 1'b0;
      @(negedge clk);
      set_req(4'b1111, 4'b1111, {rr_d[3], rr_d[2], rr_d[1], rr_d[0]});
      for (int i = 0; i < 5; i++) begin
         w = STRICT ? 0 : (i % 4);
         wr_exp_q.push_back(wr_e(cyc, 4'(1 << w), word(1'b1, 2'(w), rr_d[w])));
         pend_q.push_back(word(1'b1, 2'(w), rr_d[w]));
         @(negedge clk);
      end
      set_req(4'b0000, 4'b0000, 64'h0);
      repeat (3) @(negedge clk);
      #1;
      chk("held_state_idle", 64'(bus.dbg_state), 64'h0);

      // Drain five tasks: reads every OP_GAP+2 = 4 cycles.
      @(negedge clk);
      c = cyc;
      bus.pifo_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rd_exp_q.push_back(64'(c + 1 + 4 * i));
         task_exp_q.push_back(tk_e(c + 2 + 4 * i, pend_q.pop_front()));
      end
      repeat (24) @(negedge clk);

      // Tree 2 pop: payload is zeroed in the task word.
      c = cyc;
      set_req(4'b0100, 4'b0000, {4{16'hBEEF}});
      wr_exp_q.push_back(wr_e(c, 4'b0100, {1'b0, 2'd2, 16'h0000}));
      rd_exp_q.push_back(64'(c + 2));
      task_exp_q.push_back(tk_e(c + 3, {1'b0, 2'd2, 16'h0000}));
      @(negedge clk);
      set_req(4'b0000, 4'b0000, 64'h0);
      repeat (8) @(negedge clk);

      // Tree 1 push into empty FIFO: read at +2, task at +3.
      c = cyc;
      set_req(4'b0010, 4'b0010, {16'h0, 16'h0, 16'h00A5, 16'h0});
      wr_exp_q.push_back(wr_e(c, 4'b0010, {1'b1, 2'd1, 16'h00A5}));
      rd_exp_q.push_back(64'(c + 2));
      task_exp_q.push_back(tk_e(c + 3, {1'b1, 2'd1, 16'h00A5}));
      @(negedge clk);
      set_req(4'b0000, 4'b0000, 64'h0);
      repeat (8) @(negedge clk);

      // Trees 0 (pop) and 3 (push) together, pointer at 2: RR gives 3,0,3.
      c = cyc;
      set_req(4'b1001, 4'b1000, {16'h1234, 16'h0, 16'h0, 16'hFFFF});
      for (int i = 0; i < 3; i++) begin
         w = STRICT ? 0 : ((i == 1) ? 0 : 3);
         wr_exp_q.push_back(wr_e(c + i, 4'(1 << w),
                                 (w == 3) ? word(1'b1, 2'd3, 16'h1234) : word(1'b0, 2'd0, 16'hFFFF)));
         rd_exp_q.push_back(64'(c + 2 + 4 * i));
         task_exp_q.push_back(tk_e(c + 3 + 4 * i,
                                   (w == 3) ? word(1'b1, 2'd3, 16'h1234) : word(1'b0, 2'd0, 16'h0)));
         @(negedge clk);
      end
      set_req(4'b0000, 4'b0000, 64'h0);
      repeat (14) @(negedge clk);

      // FIFO full: no grant, even in the cycle a read issues.
      bus.pifo_ready = 1'b0;
      c = cyc;
      set_req(4'b0100, 4'b0100, {16'h0, 16'h0F0F, 16'h0, 16'h0});
      wr_exp_q.push_back(wr_e(c, 4'b0100, {1'b1, 2'd2, 16'h0F0F}));
      @(negedge clk);
      set_req(4'b0000, 4'b0000, 64'h0);
      @(negedge clk);
      force_full = 1'b1;
      bus.pifo_ready = 1'b1;
      set_req(4'b1111, 4'b1111, {4{16'h7777}});
      rd_exp_q.push_back(64'(c + 3));
      task_exp_q.push_back(tk_e(c + 4, {1'b1, 2'd2, 16'h0F0F}));
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("full_grant", 64'(bus.req_grant),  64'h0);
         chk("full_wr_en", 64'(bus.fifo_wr_en), 64'h0);
         @(negedge clk);
      end
      force_full = 1'b0;
      set_req(4'b0000, 4'b0000, 64'h0);
      repeat (6) @(negedge clk);

      // Reset during GAP: FSM back to IDLE at once, no stray task afterwards.
      c = cyc;
      set_req(4'b0100, 4'b0100, {16'h0, 16'h5A5A, 16'h0, 16'h0});
      wr_exp_q.push_back(wr_e(c, 4'b0100, {1'b1, 2'd2, 16'h5A5A}));
      rd_exp_q.push_back(64'(c + 2));
      task_exp_q.push_back(tk_e(c + 3, {1'b1, 2'd2, 16'h5A5A}));
      @(negedge clk);
      set_req(4'b0000, 4'b0000, 64'h0);
      repeat (3) @(negedge clk);
      #1;
      chk("pre_rst_in_gap", 64'(bus.dbg_state), 64'h2);
      rst = 1'b0;
      #1;
      chk("gap_rst_state",      64'(bus.dbg_state),  64'h0);
      chk("gap_rst_task_valid", 64'(bus.task_valid), 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bus.pifo_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("post_rst_task_valid", 64'(bus.task_valid), 64'h0);

      // Pointer cleared by reset: trees 0 and 3 -> tree 0 wins.
      @(negedge clk);
      c = cyc;
      set_req(4'b1001, 4'b1001, {16'h3333, 16'h0, 16'h0, 16'h4444});
      wr_exp_q.push_back(wr_e(c, 4'b0001, {1'b1, 2'd0, 16'h4444}));
      @(negedge clk);
      set_req(4'b0000, 4'b0000, 64'h0);
      repeat (5) @(negedge clk);

      chk("wr_queue_drained",   64'(wr_exp_q.size()),   64'h0);
      chk("rd_queue_drained",   64'(rd_exp_q.size()),   64'h0);
      chk("task_queue_drained", 64'(task_exp_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
